fpu_sched: RTL and testbench
============================

# fpu_sched

Round-robin scheduler that shares the single-issue floating-point datapath among `N_REQ` requesters, such as the F-type and fused multiply-add issue queues. For each accepted operation it holds the operands and operation select stable for the operation's latency, then captures the datapath result and returns it with its tag over a valid/ready handshake. It also keeps the sticky accrued `fflags` that feed `fcsr`. The block sits between the issue queues and the FPU datapath and replaces per-instruction multicycle sequencing inside the datapath.

## Interface
- `N_REQ`, 2, number of requesters (2..4)
- `TAG_W`, 4, width of the per-request tag
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  request present, one bit per requester
- `req_ready`  out  N_REQ  grant; at most one bit high
- `req_op`  in  5*N_REQ  operation index 0..21 (fpu_pkg encoding), slice i for requester i
- `req_tag`  in  TAG_W*N_REQ  destination tag
- `req_rs1`, `req_rs2`, `req_rs3`  in  32*N_REQ  operands
- `fpu_op`  out  5  operation select to the datapath
- `fpu_rs1`, `fpu_rs2`, `fpu_rs3`  out  32  registered operands to the datapath
- `fpu_result`  in  32  datapath result
- `fpu_fflags`  in  5  datapath exception flags {NV,DZ,OF,UF,NX}
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  32  captured result
- `res_tag`  out  TAG_W  tag of the completed operation
- `res_src`  out  2  index of the requester that issued the operation
- `flags_clr`  in  1  clear the accrued flags
- `fflags_acc`  out  5  sticky accrued flags

## Operation
- **States:** IDLE, EXEC, DONE.
- **Grant condition:** `req_ready` may be high only when the block is in IDLE, or in DONE while `res_ready` is high.
  - The arbiter selects the first valid requester at or after the round-robin pointer.
  - On an accept edge (`req_valid[i] & req_ready[i]`):
    - op, operands, tag and src are registered into the `fpu_*` outputs and result metadata;
    - `cnt` is set to 0 and the state goes to EXEC;
    - the pointer is set to (i+1) mod N_REQ.
  - When no request is accepted, the pointer holds.
- **Latency L per op (from fpu_pkg):**
  - ops 0, 1, 2 (add, sub, mul): 3
  - ops 3, 17 (div, sqrt): 27
  - ops 18–21 (fused): 6
  - ops 4–16: 1
  - op > 21: illegal, L = 1
- **EXEC:**
  - `cnt` increments each cycle.
  - On the edge where `cnt == L-1`:
    - `res_data` is set to `fpu_result` (0 for an illegal op);
    - `fflags_acc` is set to `fflags_acc | fpu_fflags` (for an illegal op, 5'b10000 is used instead of `fpu_fflags`);
    - the state goes to DONE.
- **DONE:**
  - `res_valid` is high and `res_data`, `res_tag`, `res_src` are held stable.
  - When `res_ready` is high: go to EXEC if a request is accepted in the same cycle, otherwise go to IDLE.
- **Datapath outputs:** `fpu_op` and `fpu_rs*` change only on an accept edge.
- **`flags_clr`:**
  - On its own, sets `fflags_acc` to 0.
  - If it coincides with a capture edge, `fflags_acc` is set to the newly captured flags only.
- **Reset (any state, including mid-operation):** the state goes to IDLE, the in-flight op is dropped with no `res_valid`, and the pointer is set to 0.
- **Reset values:**
  - `res_valid`, `req_ready`, `fflags_acc`, `res_data`, `res_tag`, `res_src` = 0
  - `fpu_op` and `fpu_rs*` = 0

## Timing
- **Accept to result:** `res_valid` rises exactly L cycles after the accept edge. No extra cycle is spent when `res_ready` is already high.
- **Back-to-back throughput:** one op per L+1 cycles when `res_ready` is held high, because the result handshake and the next accept share a cycle.
- **Grant path:** `req_ready` is combinational from `req_valid`, the state and `res_ready`. All other outputs are registered.
- **Back-pressure:** while `res_ready` is low in DONE, no request is granted and the datapath inputs are held.

## Structure
- **fpu_pkg:**
  - operation index constants `OP_FADD`..`OP_FNMSUB` (0..21);
  - latency constants `LAT_ADD = 3`, `LAT_DIV = 27`, `LAT_FMA = 6`, `LAT_1 = 1`;
  - flag bit positions;
  - the state enum.
- **Sub-module:** `rr_arbiter`, parameterised by N_REQ. Inputs are request and pointer; outputs are a one-hot grant and the granted index. It is purely combinational; the pointer register lives in `fpu_sched`.

## Test plan
1. **Single fadd:** requester 0 issues fadd (op 0) with rs1 = 32'h3F800000, rs2 = 32'h40000000, tag 5; the model returns 32'h40400000. Required: `res_valid` exactly 3 cycles after accept, `res_data` = 32'h40400000, `res_tag` = 5, `res_src` = 0.
2. **Fairness:** both requesters hold `req_valid` with feq (op 16) and `res_ready` = 1. Required: grants alternate 0, 1, 0, 1 and one result every 2 cycles.
3. **Back-pressure on fdiv:** fdiv with `res_ready` held low for 5 cycles after `res_valid` rises. Required: `res_valid` at +27 cycles, `res_data` stable, `req_ready` = 0, and `fpu_rs1` unchanged through the stall; a pending request is accepted in the `res_ready` cycle.
4. **Flag accrual:** fdiv completes with `fpu_fflags` = 5'b01000, then fadd with 5'b00001. Required: `fflags_acc` = 5'b01001. Then `flags_clr` asserted together with a feq capture carrying 5'b10000. Required: `fflags_acc` = 5'b10000.
5. **Reset mid-operation:** `resetn` low at cycle 10 of an fdiv. Required: next cycle the block is in IDLE, `res_valid` = 0, `fflags_acc` = 0, `fpu_op` = 0, and no completion afterwards.
6. **Illegal op:** op 25 with tag 3. Required: `res_valid` 1 cycle after accept, `res_data` = 0, `res_tag` = 3, `fflags_acc[4]` = 1.

Source files
------------

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU issue scheduler: operation indices,
// per-operation latencies, exception flag bit positions and the scheduler
// state encoding. No ports.
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int OP_W   = 5;
    localparam int FLAG_W = 5;

    // Operation indices presented on req_op / fpu_op.
    localparam logic [OP_W-1:0] OP_FADD      = 5'd0;
    localparam logic [OP_W-1:0] OP_FSUB      = 5'd1;
    localparam logic [OP_W-1:0] OP_FMUL      = 5'd2;
    localparam logic [OP_W-1:0] OP_FDIV      = 5'd3;
    localparam logic [OP_W-1:0] OP_FMIN      = 5'd4;
    localparam logic [OP_W-1:0] OP_FMAX      = 5'd5;
    localparam logic [OP_W-1:0] OP_FSGNJ     = 5'd6;
    localparam logic [OP_W-1:0] OP_FSGNJN    = 5'd7;
    localparam logic [OP_W-1:0] OP_FSGNJX    = 5'd8;
    localparam logic [OP_W-1:0] OP_FCVT_W_S  = 5'd9;
    localparam logic [OP_W-1:0] OP_FCVT_WU_S = 5'd10;
    localparam logic [OP_W-1:0] OP_FCVT_S_W  = 5'd11;
    localparam logic [OP_W-1:0] OP_FCVT_S_WU = 5'd12;
    localparam logic [OP_W-1:0] OP_FCLASS    = 5'd13;
    localparam logic [OP_W-1:0] OP_FLT       = 5'd14;
    localparam logic [OP_W-1:0] OP_FLE       = 5'd15;
    localparam logic [OP_W-1:0] OP_FEQ       = 5'd16;
    localparam logic [OP_W-1:0] OP_FSQRT     = 5'd17;
    localparam logic [OP_W-1:0] OP_FMADD     = 5'd18;
    localparam logic [OP_W-1:0] OP_FMSUB     = 5'd19;
    localparam logic [OP_W-1:0] OP_FNMADD    = 5'd20;
    localparam logic [OP_W-1:0] OP_FNMSUB    = 5'd21;

    // Cycles the datapath needs with stable inputs before its result is valid.
    localparam logic [4:0] LAT_ADD = 5'd3;
    localparam logic [4:0] LAT_DIV = 5'd27;
    localparam logic [4:0] LAT_FMA = 5'd6;
    localparam logic [4:0] LAT_1   = 5'd1;

    // Bit positions inside fflags {NV,DZ,OF,UF,NX}.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_FNMSUB;
    endfunction

    // Illegal ops fall into the default and complete after one cycle.
    function automatic logic [4:0] op_latency(input logic [OP_W-1:0] op);
        logic [4:0] lat;
        case (op)
            OP_FADD, OP_FSUB, OP_FMUL:               lat = LAT_ADD;
            OP_FDIV, OP_FSQRT:                       lat = LAT_DIV;
            OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB: lat = LAT_FMA;
            default:                                 lat = LAT_1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_sched_if.sv
// ---------------------------------------------------------------------------
// fpu_sched_if
// Request and result handshake bundle between the issue queues / result
// consumer (master) and the FPU scheduler (slave).
//   req_valid/req_ready   per-requester valid/grant, one bit each
//   req_op/tag/rs1..rs3   packed per-requester operation, slice i = requester i
//   res_valid/res_ready   result handshake
//   res_data/tag/src      captured result, its tag and issuing requester
// ---------------------------------------------------------------------------
interface fpu_sched_if #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [5*N_REQ-1:0]     req_op;
    logic [TAG_W*N_REQ-1:0] req_tag;
    logic [32*N_REQ-1:0]    req_rs1;
    logic [32*N_REQ-1:0]    req_rs2;
    logic [32*N_REQ-1:0]    req_rs3;

    logic                   res_valid;
    logic                   res_ready;
    logic [31:0]            res_data;
    logic [TAG_W-1:0]       res_tag;
    logic [1:0]             res_src;

    modport master (
        output req_valid, req_op, req_tag, req_rs1, req_rs2, req_rs3,
        input  req_ready,
        input  res_valid, res_data, res_tag, res_src,
        output res_ready
    );

    modport slave (
        input  req_valid, req_op, req_tag, req_rs1, req_rs2, req_rs3,
        output req_ready,
        output res_valid, res_data, res_tag, res_src,
        input  res_ready
    );
endinterface

// File: rtl/fpu_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping around. The pointer register is owned by the caller.
//   req_i  requests, one bit per requester
//   ptr_i  index with highest priority this cycle
//   gnt_o  one-hot grant (all zero when nothing is requested)
//   idx_o  index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       idx_o
);

    always_comb begin
        logic found;
        int   j;
        // NOTE: every output and local gets a default before the loop so no
        // path through the block leaves a value unassigned (no latches).
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = 2'(j);
            end
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// ---------------------------------------------------------------------------
// fpu_sched
// Shares one single-issue FPU datapath among N_REQ requesters. Accepts one
// operation at a time, holds its operands for the op's latency, captures the
// datapath result and returns it over a valid/ready handshake. Also keeps
// the sticky accrued fflags for fcsr.
//   clk, resetn      clock, synchronous active-low reset
//   bus (slave)      request grant + result handshake, see fpu_sched_if
//   fpu_op_o, fpu_rs1_o..fpu_rs3_o   registered datapath inputs
//   fpu_result_i, fpu_fflags_i       datapath outputs
//   flags_clr_i      clear accrued flags
//   fflags_acc_o     sticky accrued flags {NV,DZ,OF,UF,NX}
// ---------------------------------------------------------------------------
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                resetn,
    fpu_sched_if.slave          bus,
    output logic [OP_W-1:0]     fpu_op_o,
    output logic [31:0]         fpu_rs1_o,
    output logic [31:0]         fpu_rs2_o,
    output logic [31:0]         fpu_rs3_o,
    input  logic [31:0]         fpu_result_i,
    input  logic [FLAG_W-1:0]   fpu_fflags_i,
    input  logic                flags_clr_i,
    output logic [FLAG_W-1:0]   fflags_acc_o
);

    state_e             state_q, state_d;
    logic [4:0]         cnt_q;
    logic [1:0]         ptr_q;
    logic [OP_W-1:0]    op_q;
    logic [31:0]        rs1_q, rs2_q, rs3_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         src_q;
    logic [31:0]        data_q;
    logic [FLAG_W-1:0]  flags_q, flags_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [1:0]         arb_idx;
    logic               grant_en;
    logic               accept;
    logic               capture;
    logic [1:0]         ptr_next;

    logic [OP_W-1:0]    sel_op;
    logic [TAG_W-1:0]   sel_tag;
    logic [31:0]        sel_rs1, sel_rs2, sel_rs3;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // A new op may only start when the datapath is free: idle, or the
    // current result leaves this very cycle.
    assign grant_en = resetn &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE && bus.res_ready));
    assign accept   = grant_en && (|arb_gnt);
    assign capture  = (state_q == ST_EXEC) && (cnt_q == op_latency(op_q) - 5'd1);
    assign ptr_next = (arb_idx == 2'(N_REQ - 1)) ? 2'd0 : arb_idx + 2'd1;

    // Operand mux for the granted requester.
    always_comb begin
        sel_op  = '0;
        sel_tag = '0;
        sel_rs1 = '0;
        sel_rs2 = '0;
        sel_rs3 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_op  = bus.req_op[5*i +: 5];
                sel_tag = bus.req_tag[TAG_W*i +: TAG_W];
                sel_rs1 = bus.req_rs1[32*i +: 32];
                sel_rs2 = bus.req_rs2[32*i +: 32];
                sel_rs3 = bus.req_rs3[32*i +: 32];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: if (capture) state_d = ST_DONE;
            ST_DONE: if (bus.res_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready = grant_en ? arb_gnt : '0;
        bus.res_valid = (state_q == ST_DONE);
    end

    // A clear coinciding with a capture keeps only the newly captured flags.
    always_comb begin
        flags_d = flags_clr_i ? '0 : flags_q;
        if (capture)
            flags_d = flags_d | (op_illegal(op_q) ? FLAG_W'(1 << FLAG_NV) : fpu_fflags_i);
    end

    // ---------------- Datapath / result registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; every register here is
        // explicitly cleared so the datapath inputs read 0 after reset.
        if (!resetn) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
            tag_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
            if (accept) begin
                cnt_q <= '0;
                ptr_q <= ptr_next;
                op_q  <= sel_op;
                rs1_q <= sel_rs1;
                rs2_q <= sel_rs2;
                rs3_q <= sel_rs3;
                tag_q <= sel_tag;
                src_q <= arb_idx;
            end else if (state_q == ST_EXEC) begin
                cnt_q <= cnt_q + 5'd1;
            end
            if (capture)
                data_q <= op_illegal(op_q) ? 32'd0 : fpu_result_i;
        end
    end

    assign fpu_op_o     = op_q;
    assign fpu_rs1_o    = rs1_q;
    assign fpu_rs2_o    = rs2_q;
    assign fpu_rs3_o    = rs3_q;
    assign bus.res_data = data_q;
    assign bus.res_tag  = tag_q;
    assign bus.res_src  = src_q;
    assign fflags_acc_o = flags_q;

endmodule

// File: tb/tb_fpu_sched.sv
// ---------------------------------------------------------------------------
// tb_fpu_sched
// Directed bench for fpu_sched with a result scoreboard. The datapath model
// returns rs1 ^ rs2 unless a forced value is selected.
// ---------------------------------------------------------------------------
module tb_fpu_sched;
    import fpu_pkg::*;

    localparam int N_REQ = 2;
    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       src;
    } exp_t;

    logic clk;
    logic resetn;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_fflags;
    logic [4:0]  fpu_op;
    logic [31:0] fpu_rs1, fpu_rs2, fpu_rs3;
    logic        flags_clr;
    logic [4:0]  fflags_acc;

    logic        dp_force;
    logic [31:0] dp_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_edge = 0;
    exp_t sb[$];
    int grant_log[$];
    int acc_edges[$];
    int res_edges[$];

    fpu_sched_if #(.N_REQ(N_REQ), .TAG_W(TAG_W)) bus ();

    fpu_sched #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .fpu_op_o     (fpu_op),
        .fpu_rs1_o    (fpu_rs1),
        .fpu_rs2_o    (fpu_rs2),
        .fpu_rs3_o    (fpu_rs3),
        .fpu_result_i (fpu_result),
        .fpu_fflags_i (fpu_fflags),
        .flags_clr_i  (flags_clr),
        .fflags_acc_o (fflags_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fpu_result = dp_force ? dp_value : (fpu_rs1 ^ fpu_rs2);

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        if (op > 5'd21) return 32'd0;
        if (dp_force) return dp_value;
        return a ^ b;
    endfunction

    // One clock: settle, log handshakes into the scoreboard, advance past the edge.
    task automatic step();
        logic acc, hs;
        int   gi;
        exp_t e;
        #1;
        acc = |(bus.req_valid & bus.req_ready);
        hs  = bus.res_valid & bus.res_ready;
        if (hs) begin
            chk("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data", bus.res_data, e.data);
                chk("sb_tag", 32'(bus.res_tag), 32'(e.tag));
                chk("sb_src", 32'(bus.res_src), 32'(e.src));
            end
            res_edges.push_back(cyc + 1);
        end
        if (acc) begin
            gi     = bus.req_ready[1] ? 1 : 0;
            e.data = model(bus.req_op[5*gi +: 5], bus.req_rs1[32*gi +: 32], bus.req_rs2[32*gi +: 32]);
            e.tag  = bus.req_tag[TAG_W*gi +: TAG_W];
            e.src  = 2'(gi);
            sb.push_back(e);
            grant_log.push_back(gi);
            acc_edges.push_back(cyc + 1);
            last_acc_edge = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [3:0] tag,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_op[5*i +: 5]          = op;
        bus.req_tag[TAG_W*i +: TAG_W] = tag;
        bus.req_rs1[32*i +: 32]       = a;
        bus.req_rs2[32*i +: 32]       = b;
        bus.req_rs3[32*i +: 32]       = 32'd0;
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int lat);
        int n = 0;
        while (!bus.res_valid && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_valid_seen"}, {31'd0, bus.res_valid}, 32'd1);
        lat = cyc - last_acc_edge;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int   lat;
        int   vcount;
        logic [31:0] held;

        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_tag   = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rs3   = '0;
        bus.res_ready = 1'b0;
        fpu_fflags    = '0;
        flags_clr     = 1'b0;
        dp_force      = 1'b0;
        dp_value      = '0;

        // Reset state.
        do_reset();
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_fflags", 32'(fflags_acc), 32'd0);
        chk("rst_fpu_op", 32'(fpu_op), 32'd0);
        chk("rst_fpu_rs1", fpu_rs1, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_tag", 32'(bus.res_tag), 32'd0);

        // 1. Single fadd.
        dp_force = 1'b1;
        dp_value = 32'h40400000;
        set_req(0, OP_FADD, 4'd5, 32'h3F800000, 32'h40000000);
        bus.req_valid = 2'b01;
        step();
        chk("t1_accepted", 32'(grant_log.size()), 32'd1);
        bus.req_valid = 2'b00;
        wait_valid("t1", 10, lat);
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_data", bus.res_data, 32'h40400000);
        chk("t1_tag", 32'(bus.res_tag), 32'd5);
        chk("t1_src", 32'(bus.res_src), 32'd0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        dp_force = 1'b0;

        // 2. Fairness with both requesters issuing feq.
        do_reset();
        grant_log.delete();
        acc_edges.delete();
        res_edges.delete();
        set_req(0, OP_FEQ, 4'd1, 32'hA0A0A0A0, 32'h0000FFFF);
        set_req(1, OP_FEQ, 4'd2, 32'hB1B1B1B1, 32'hFFFF0000);
        bus.res_ready = 1'b1;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 9; k++) step();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        chk("t2_drained", 32'(sb.size()), 32'd0);
        chk("t2_n_grants", {31'd0, grant_log.size() >= 4}, 32'd1);
        chk("t2_n_results", {31'd0, res_edges.size() >= 4}, 32'd1);
        if (grant_log.size() >= 4 && res_edges.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("t2_grant%0d", k), 32'(grant_log[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++) begin
                chk($sformatf("t2_acc_gap%0d", k), 32'(acc_edges[k] - acc_edges[k-1]), 32'd2);
                chk($sformatf("t2_res_gap%0d", k), 32'(res_edges[k] - res_edges[k-1]), 32'd2);
            end
        end
        bus.res_ready = 1'b0;
        step();

        // 3. fdiv under back-pressure with a pending fadd; 4a. flag accrual.
        set_req(0, OP_FDIV, 4'd7, 32'h11111111, 32'h22222222);
        set_req(1, OP_FADD, 4'd9, 32'h33333333, 32'h44444444);
        fpu_fflags = 5'b01000;
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b10;
        wait_valid("t3", 40, lat);
        chk("t3_latency", 32'(lat), 32'd27);
        chk("t3_flags_div", 32'(fflags_acc), 32'b01000);
        held = bus.res_data;
        chk("t3_data", held, 32'h11111111 ^ 32'h22222222);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t3_stall_data", bus.res_data, held);
            chk("t3_stall_ready", 32'(bus.req_ready), 32'd0);
            chk("t3_stall_rs1", fpu_rs1, 32'h11111111);
        end
        fpu_fflags = 5'b00001;
        bus.res_ready = 1'b1;
        #1;
        chk("t3_grant_in_hs", 32'(bus.req_ready), 32'b10);
        step();
        chk("t3_pending_accepted", 32'(fpu_op), 32'(OP_FADD));
        bus.req_valid = 2'b00;
        wait_valid("t4a", 10, lat);
        chk("t4a_latency", 32'(lat), 32'd3);
        chk("t4a_flags", 32'(fflags_acc), 32'b01001);
        step();
        bus.res_ready = 1'b0;

        // 4b. Clear coinciding with a feq capture.
        set_req(0, OP_FEQ, 4'd4, 32'h00000005, 32'h00000006);
        fpu_fflags = 5'b10000;
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        chk("t4b_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("t4b_flags", 32'(fflags_acc), 32'b10000);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        fpu_fflags = 5'b00000;

        // 5. Reset in the middle of an fdiv.
        set_req(0, OP_FDIV, 4'd6, 32'h55555555, 32'h66666666);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 10; k++) step();
        resetn = 1'b0;
        step();
        chk("t5_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t5_fflags", 32'(fflags_acc), 32'd0);
        chk("t5_fpu_op", 32'(fpu_op), 32'd0);
        chk("t5_fpu_rs1", fpu_rs1, 32'd0);
        chk("t5_req_ready", 32'(bus.req_ready), 32'd0);
        resetn = 1'b1;
        sb.delete();
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.res_valid) vcount++;
        end
        chk("t5_no_completion", 32'(vcount), 32'd0);

        // 6. Illegal op.
        set_req(1, 5'd25, 4'd3, 32'h77777777, 32'h88888888);
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        wait_valid("t6", 5, lat);
        chk("t6_latency", 32'(lat), 32'd1);
        chk("t6_data", bus.res_data, 32'd0);
        chk("t6_tag", 32'(bus.res_tag), 32'd3);
        chk("t6_src", 32'(bus.res_src), 32'd1);
        chk("t6_nv", 32'(fflags_acc[FLAG_NV]), 32'd1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;

        // Clear on its own.
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        chk("clr_alone", 32'(fflags_acc), 32'd0);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
